// File: rtl/dog_update_scheduler.sv
// Per-frame sequencer for the shared dog update unit. Each accepted frame tick
// issues at most one round-robin kick, then one step per enabled dog in index order.
module dog_update_scheduler #(
  parameter int unsigned N_DOGS = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic [N_DOGS-1:0] enable_mask,
  input  logic [1:0]        kick_req,
  input  logic [IDX_W-1:0]  kick_dog0,
  input  logic [IDX_W-1:0]  kick_dog1,
  output logic [1:0]        kick_ack,
  output logic              upd_valid,
  output logic              upd_op,
  output logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_ready,
  input  logic              upd_done,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_overrun,
  output logic [7:0]        overrun_cnt,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e             state_q;
  logic [N_DOGS-1:0]  mask_q;
  logic               op_q;
  logic [IDX_W-1:0]   idx_q;
  logic               win_q;
  logic               last_kick_q;
  logic               valid_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               overrun_q;
  logic [7:0]         overrun_cnt_q;
  logic [15:0]        frame_count_q;

  logic               xfer;
  logic               kick_win;
  logic [N_DOGS-1:0]  mask_left;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_DOGS-1:0] m);
    lowest_idx = '0;
    for (int i = int'(N_DOGS) - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign xfer = (state_q == StIssue) && upd_ready;

  // On contention the player that did not win last time gets the kick.
  assign kick_win = (kick_req == 2'b11) ? ~last_kick_q : kick_req[1];

  // Kicks leave the step mask untouched; a completed step retires its dog.
  always_comb begin
    mask_left = mask_q;
    if (!op_q) mask_left[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      op_q          <= 1'b0;
      idx_q         <= '0;
      win_q         <= 1'b0;
      last_kick_q   <= 1'b1;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;

      if (frame_tick && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
        if (overrun_cnt_q != 8'hff) overrun_cnt_q <= overrun_cnt_q + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (frame_tick) begin
            mask_q        <= enable_mask;
            frame_count_q <= frame_count_q + 16'd1;
            if (|kick_req) begin
              op_q    <= 1'b1;
              idx_q   <= kick_win ? kick_dog1 : kick_dog0;
              win_q   <= kick_win;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StIssue;
            end else if (|enable_mask) begin
              op_q    <= 1'b0;
              idx_q   <= lowest_idx(enable_mask);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= StIssue;
            end else begin
              frame_done_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (upd_ready) begin
            valid_q <= 1'b0;
            state_q <= StWait;
            if (op_q) last_kick_q <= win_q;
          end
        end
        StWait: begin
          if (upd_done) begin
            mask_q <= mask_left;
            if (|mask_left) begin
              op_q    <= 1'b0;
              idx_q   <= lowest_idx(mask_left);
              valid_q <= 1'b1;
              state_q <= StIssue;
            end else begin
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= StIdle;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Ack is tied to the transfer cycle itself, so it cannot fire outside ISSUE.
  assign kick_ack      = (xfer && op_q) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign upd_valid     = valid_q;
  assign upd_op        = op_q;
  assign upd_idx       = idx_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign frame_overrun = overrun_q;
  assign overrun_cnt   = overrun_cnt_q;
  assign frame_count   = frame_count_q;

endmodule
